// File: rtl/mode_apply_ctrl_if.sv
// Handshake/bus bundle for mode_apply_ctrl: flag word and frame sync in, applied mode out.
// The slave modport is the controller's view; master is the upstream/pipeline side.
interface mode_apply_ctrl_if #(
  parameter int FLAG_W = 8
);
  localparam int SEL_W = $clog2(FLAG_W);

  logic [FLAG_W-1:0] mode_flags;
  logic              vsync;
  logic              mode_ack;
  logic [SEL_W-1:0]  mode_sel;
  logic              mode_active;
  logic              mode_valid;
  logic              busy;
  logic              err_timeout;

  modport master (
    output mode_flags, vsync, mode_ack,
    input  mode_sel, mode_active, mode_valid, busy, err_timeout
  );

  modport slave (
    input  mode_flags, vsync, mode_ack,
    output mode_sel, mode_active, mode_valid, busy, err_timeout
  );
endinterface

// File: rtl/mode_apply_ctrl.sv
// Frame-aligned mode dispatcher: settles the flag word, priority-encodes it, hands off on vsync rise.
// Optional ack timeout enabled by defining MODE_TIMEOUT_EN.
module mode_apply_ctrl #(
  parameter int FLAG_W      = 8,
  parameter int SETTLE_CYC  = 2_000_000,
  parameter int ACK_TIMEOUT = 1_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  mode_apply_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(FLAG_W);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_WAIT_ACK
  } state_t;

  state_t             r_state;
  logic [FLAG_W-1:0]  r_flags_d;
  logic [CNT_W-1:0]   r_settle_cnt;
  logic               r_vsync_d;
  logic [SEL_W-1:0]   r_mode_sel;
  logic               r_mode_active;
  logic               r_mode_valid;

  logic               w_settled;
  logic               w_vs_rise;
  logic               w_change;
  logic               w_cand_active;
  logic [SEL_W-1:0]   w_cand_sel;

`ifdef MODE_TIMEOUT_EN
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  logic [ACK_W-1:0]   r_ack_cnt;
  logic               r_err_timeout;
`endif

  // Any movement of the flag word restarts the settle window; the count saturates once settled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags_d    <= '0;
      r_settle_cnt <= '0;
      r_vsync_d    <= 1'b0;
    end else begin
      r_vsync_d <= bus.vsync;
      if (bus.mode_flags != r_flags_d) begin
        r_flags_d    <= bus.mode_flags;
        r_settle_cnt <= '0;
      end else if (!w_settled) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

  assign w_settled = (r_settle_cnt == CNT_W'(SETTLE_CYC));
  assign w_vs_rise = bus.vsync & ~r_vsync_d;

  always_comb begin
    w_cand_sel = '0;
    for (int i = 0; i < FLAG_W; i++) begin
      if (r_flags_d[i]) w_cand_sel = SEL_W'(i);
    end
  end

  assign w_cand_active = |r_flags_d;
  assign w_change      = w_settled &&
                         ({w_cand_active, w_cand_sel} != {r_mode_active, r_mode_sel});

  // Applied mode only moves on the PENDING->WAIT_ACK step, so it is frozen while valid is up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_mode_sel    <= '0;
      r_mode_active <= 1'b0;
      r_mode_valid  <= 1'b0;
`ifdef MODE_TIMEOUT_EN
      r_ack_cnt     <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_change) r_state <= ST_PENDING;
        end
        ST_PENDING: begin
          if (!w_settled) begin
            r_state <= ST_IDLE;
          end else if (w_vs_rise) begin
            r_mode_sel    <= w_cand_sel;
            r_mode_active <= w_cand_active;
            r_mode_valid  <= 1'b1;
            r_state       <= ST_WAIT_ACK;
`ifdef MODE_TIMEOUT_EN
            r_ack_cnt     <= '0;
`endif
          end
        end
        ST_WAIT_ACK: begin
          if (r_mode_valid && bus.mode_ack) begin
            r_mode_valid  <= 1'b0;
            r_state       <= ST_IDLE;
`ifdef MODE_TIMEOUT_EN
            r_err_timeout <= 1'b0;
          end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            r_mode_valid  <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_ack_cnt     <= r_ack_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mode_sel    = r_mode_sel;
  assign bus.mode_active = r_mode_active;
  assign bus.mode_valid  = r_mode_valid;
  assign bus.busy        = (r_state != ST_IDLE);
`ifdef MODE_TIMEOUT_EN
  assign bus.err_timeout = r_err_timeout;
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_mode_apply_ctrl.sv
// Self-checking bench for mode_apply_ctrl (SETTLE_CYC=4, ACK_TIMEOUT=16).
// Covers both builds; the timeout sequence follows MODE_TIMEOUT_EN.
module tb_mode_apply_ctrl;
  localparam int FLAG_W = 8;
  localparam int SETTLE = 4;
  localparam int ACK_TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mode_apply_ctrl_if #(.FLAG_W(FLAG_W)) bus ();

  mode_apply_ctrl #(
    .FLAG_W     (FLAG_W),
    .SETTLE_CYC (SETTLE),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [7:0] flags;
    logic       expReq;
    logic [2:0] expSel;
    logic       expActive;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full transaction: change flags, settle, vsync pulse, then ack (if a request is expected).
  task automatic applyStimulus(input vec_t v);
    bus.mode_flags = v.flags;
    cycles(SETTLE + 4);
    checkOutput({v.name, " busy_pending"}, 8'(bus.busy), 8'(v.expReq));
    checkOutput({v.name, " valid_pre"}, 8'(bus.mode_valid), 8'h00);
    bus.vsync = 1'b1;
    cycles(1);
    bus.vsync = 1'b0;
    checkOutput({v.name, " valid_at_vsync"}, 8'(bus.mode_valid), 8'(v.expReq));
    checkOutput({v.name, " sel"}, 8'(bus.mode_sel), 8'(v.expSel));
    checkOutput({v.name, " active"}, 8'(bus.mode_active), 8'(v.expActive));
    cycles(1);
    if (v.expReq) begin
      checkOutput({v.name, " valid_held"}, 8'(bus.mode_valid), 8'h01);
      bus.mode_ack = 1'b1;
      cycles(1);
      bus.mode_ack = 1'b0;
      checkOutput({v.name, " valid_after_ack"}, 8'(bus.mode_valid), 8'h00);
      checkOutput({v.name, " sel_after_ack"}, 8'(bus.mode_sel), 8'(v.expSel));
    end
    checkOutput({v.name, " busy_end"}, 8'(bus.busy), 8'h00);
  endtask

  initial begin
    logic [7:0] toggleSeq [3];
    logic       sawValid;
    logic       heldValid;
    vec_t       tv;

    vecs[0] = '{8'h05, 1'b1, 3'd2, 1'b1, "f05"};
    vecs[1] = '{8'h00, 1'b1, 3'd0, 1'b0, "f00"};
    vecs[2] = '{8'h80, 1'b1, 3'd7, 1'b1, "f80"};
    vecs[3] = '{8'hC0, 1'b0, 3'd7, 1'b1, "fC0_same"};
    vecs[4] = '{8'h10, 1'b1, 3'd4, 1'b1, "f10"};
    vecs[5] = '{8'h01, 1'b1, 3'd0, 1'b1, "f01"};
    vecs[6] = '{8'h7F, 1'b1, 3'd6, 1'b1, "f7F"};
    vecs[7] = '{8'h00, 1'b1, 3'd0, 1'b0, "f00_end"};

    bus.mode_flags = 8'h00;
    bus.vsync      = 1'b0;
    bus.mode_ack   = 1'b0;

    cycles(3);
    checkOutput("rst sel", 8'(bus.mode_sel), 8'h00);
    checkOutput("rst active", 8'(bus.mode_active), 8'h00);
    checkOutput("rst valid", 8'(bus.mode_valid), 8'h00);
    checkOutput("rst busy", 8'(bus.busy), 8'h00);
    checkOutput("rst err", 8'(bus.err_timeout), 8'h00);
    rst_n = 1'b1;
    bus.mode_ack = 1'b1;
    cycles(10);
    bus.mode_ack = 1'b0;
    checkOutput("zero flags busy", 8'(bus.busy), 8'h00);
    checkOutput("zero flags valid", 8'(bus.mode_valid), 8'h00);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Flags never settle while toggling, so the vsync in the middle must not trigger a transfer.
    toggleSeq[0] = 8'h01;
    toggleSeq[1] = 8'h03;
    toggleSeq[2] = 8'h02;
    sawValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mode_flags = toggleSeq[i];
      cycles(1);
      if (bus.mode_valid) sawValid = 1'b1;
      bus.vsync = (i == 1);
      cycles(1);
      if (bus.mode_valid) sawValid = 1'b1;
    end
    bus.vsync = 1'b0;
    checkOutput("toggle no_valid", 8'(sawValid), 8'h00);
    tv = '{8'h02, 1'b1, 3'd1, 1'b1, "toggle_final"};
    applyStimulus(tv);

    bus.mode_flags = 8'h80;
    bus.vsync      = 1'b1;
    cycles(SETTLE + 6);
    checkOutput("vsync_held busy", 8'(bus.busy), 8'h01);
    checkOutput("vsync_held valid", 8'(bus.mode_valid), 8'h00);
    bus.vsync = 1'b0;
    cycles(1);
    checkOutput("vsync_low valid", 8'(bus.mode_valid), 8'h00);
    bus.vsync = 1'b1;
    cycles(1);
    bus.vsync = 1'b0;
    checkOutput("vsync_rerise valid", 8'(bus.mode_valid), 8'h01);
    checkOutput("vsync_rerise sel", 8'(bus.mode_sel), 8'h07);
    bus.mode_ack = 1'b1;
    cycles(1);
    bus.mode_ack = 1'b0;
    checkOutput("vsync_rerise ack", 8'(bus.mode_valid), 8'h00);

    bus.mode_flags = 8'h03;
    cycles(SETTLE + 4);
    bus.vsync = 1'b1;
    cycles(1);
    bus.vsync = 1'b0;
    checkOutput("noack valid_rise", 8'(bus.mode_valid), 8'h01);
`ifdef MODE_TIMEOUT_EN
    cycles(ACK_TO - 1);
    checkOutput("timeout valid_before", 8'(bus.mode_valid), 8'h01);
    checkOutput("timeout err_before", 8'(bus.err_timeout), 8'h00);
    cycles(1);
    checkOutput("timeout valid_drop", 8'(bus.mode_valid), 8'h00);
    checkOutput("timeout err_set", 8'(bus.err_timeout), 8'h01);
    checkOutput("timeout busy", 8'(bus.busy), 8'h00);
    checkOutput("timeout sel_kept", 8'(bus.mode_sel), 8'h01);
    tv = '{8'h20, 1'b1, 3'd5, 1'b1, "after_timeout"};
    applyStimulus(tv);
    checkOutput("timeout err_cleared", 8'(bus.err_timeout), 8'h00);
`else
    heldValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (!bus.mode_valid || bus.err_timeout) heldValid = 1'b0;
    end
    checkOutput("noack valid_held_100", 8'(heldValid), 8'h01);
    checkOutput("noack err", 8'(bus.err_timeout), 8'h00);
    bus.mode_ack = 1'b1;
    cycles(1);
    bus.mode_ack = 1'b0;
    checkOutput("late_ack valid", 8'(bus.mode_valid), 8'h00);
    checkOutput("late_ack sel", 8'(bus.mode_sel), 8'h01);
`endif

    // Reset while a mode is in flight drops it; held flags re-request after the settle window.
    bus.mode_flags = 8'h10;
    cycles(SETTLE + 4);
    bus.vsync = 1'b1;
    cycles(1);
    bus.vsync = 1'b0;
    checkOutput("pre_reset valid", 8'(bus.mode_valid), 8'h01);
    rst_n = 1'b0;
    cycles(1);
    checkOutput("mid_reset sel", 8'(bus.mode_sel), 8'h00);
    checkOutput("mid_reset active", 8'(bus.mode_active), 8'h00);
    checkOutput("mid_reset valid", 8'(bus.mode_valid), 8'h00);
    checkOutput("mid_reset busy", 8'(bus.busy), 8'h00);
    checkOutput("mid_reset err", 8'(bus.err_timeout), 8'h00);
    rst_n = 1'b1;
    cycles(SETTLE + 1);
    checkOutput("post_reset busy_settling", 8'(bus.busy), 8'h00);
    cycles(1);
    checkOutput("post_reset busy_pending", 8'(bus.busy), 8'h01);
    bus.vsync = 1'b1;
    cycles(1);
    bus.vsync = 1'b0;
    checkOutput("post_reset valid", 8'(bus.mode_valid), 8'h01);
    checkOutput("post_reset sel", 8'(bus.mode_sel), 8'h04);
    checkOutput("post_reset active", 8'(bus.mode_active), 8'h01);
    bus.mode_ack = 1'b1;
    cycles(1);
    bus.mode_ack = 1'b0;
    checkOutput("post_reset ack", 8'(bus.mode_valid), 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/mode_apply_ctrl.md
# mode_apply_ctrl

Frame-aligned mode dispatcher sitting directly downstream of the key/LED mode-flag register in the 100 MHz AXI clock domain. It takes the 8-bit toggle-flag word, waits for it to settle, priority-encodes it into a single processing-mode index, and hands the new mode to the video pipeline. Hand-off happens only on a frame boundary (vsync rising edge) through a valid/ack handshake, so the pipeline never switches mid-frame.

## Interface
- FLAG_W, 8, number of mode flags; SEL_W = $clog2(FLAG_W) (localparam, 3 at default)
- SETTLE_CYC, 2_000_000, cycles the flag word must be unchanged before it counts as a request (20 ms at 100 MHz)
- ACK_TIMEOUT, 1_000_000, cycles to wait for mode_ack (used only with MODE_TIMEOUT_EN)

- clk  in  1  100 MHz system clock
- rst_n  in  1  synchronous, active-low reset
- mode_flags  in  FLAG_W  mode toggle flags from upstream, level, clk domain
- vsync  in  1  frame sync, active-high level, already synchronised to clk
- mode_ack  in  1  pipeline accepts mode_sel/mode_active
- mode_sel  out  SEL_W  applied mode index
- mode_active  out  1  1 = some mode selected, 0 = bypass
- mode_valid  out  1  handshake valid, held until acked
- busy  out  1  FSM not in IDLE
- err_timeout  out  1  sticky ack-timeout flag

## Operation
- Reset values: mode_sel=0, mode_active=0, mode_valid=0, busy=0, err_timeout=0; flags_d=0, settle_cnt=0, vsync_d=0, state IDLE. Applied mode after reset is {active=0, sel=0}.
- Settle: flags_d registers mode_flags. If mode_flags != flags_d: flags_d<=mode_flags, settle_cnt<=0; else settle_cnt increments, saturating at SETTLE_CYC. settled = (settle_cnt == SETTLE_CYC).
- Encode: cand_sel = index of highest set bit of flags_d; cand_active = |flags_d; all-zero gives {0,0}.
- change = settled && {cand_active,cand_sel} != {mode_active,mode_sel}.
- vs_rise = vsync & ~vsync_d; vsync_d <= vsync every cycle.
- FSM:
  - IDLE: change -> PENDING. vsync ignored.
  - PENDING: if !settled -> IDLE (flags moved; restart settle). Else if vs_rise: load mode_sel<=cand_sel, mode_active<=cand_active, mode_valid<=1 -> WAIT_ACK.
  - WAIT_ACK: on mode_valid && mode_ack: mode_valid<=0, err_timeout<=0 -> IDLE. Flag changes here do not alter mode_sel; they are picked up after returning to IDLE.
- mode_sel/mode_active change only on the PENDING->WAIT_ACK transition; stable while mode_valid=1.
- mode_ack outside WAIT_ACK is ignored.
- busy = (state != IDLE).

## Timing
- Flag change sampled at edge N: settled at edge N+SETTLE_CYC; change visible that cycle; PENDING entered at edge N+SETTLE_CYC+1.
- vsync first sampled high at edge M while in PENDING and settled: mode_sel, mode_active, mode_valid updated at edge M (outputs visible after M); no extra latency.
- Handshake completes at first edge with mode_valid=1 and mode_ack=1; mode_valid low after that edge, state IDLE. Earliest completion is the edge after mode_valid rises.
- vsync held high: only one vs_rise; next transfer waits for a new low-to-high transition.
- Reset asserted at any point: all outputs return to reset values at that edge; a pending or in-flight mode is dropped. Nonzero flags after reset re-request after SETTLE_CYC.

## Configuration
- MODE_TIMEOUT_EN defined: a counter runs in WAIT_ACK; when ACK_TIMEOUT cycles elapse without ack: mode_valid<=0, err_timeout<=1 (sticky until reset or next successful ack), -> IDLE; applied mode keeps the new value. Ack on the same edge as expiry counts as success.
- Not defined: no counter; WAIT_ACK waits indefinitely; err_timeout tied to 0.

## Test plan
Params for bench: SETTLE_CYC=4, ACK_TIMEOUT=16.
- Flags 0x00 -> 0x05, vsync pulse after settle, ack one cycle later -> mode_sel=2, mode_active=1, mode_valid high exactly from vsync edge to ack edge; busy=0 afterwards.
- Flags 0x05 -> 0x00 settled, vsync -> mode_active=0, mode_sel=0 via full handshake; flags 0x00 at reset -> no request, busy stays 0.
- Flags change 0x01 -> 0x03 -> 0x02 every 2 cycles, vsync during toggling -> no mode_valid; after settle and next vsync, mode_sel=1 only.
- Settled 0x80, vsync held high before PENDING is entered -> no transfer until vsync drops and rises again; then mode_sel=7.
- MODE_TIMEOUT_EN, no ack -> mode_valid drops 16 cycles after rising, err_timeout=1; next successful ack clears it. Without macro: mode_valid stays high for 100 cycles, err_timeout=0.
- rst_n low mid WAIT_ACK -> all outputs 0 at that edge; with flags 0x10 held, new request after 4 cycles, mode_sel=4 on next vsync.
